word_serializer: RTL and testbench

Parallel-to-serial front end for the serial pattern detectors: accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a single-bit stream that drives the detector's `x` input. A one-word holding register allows back-to-back words with no idle gap. The block qualifies each bit with `x_valid` and signals word completion.

---
 rtl/ser_pkg.sv | 20 ++
 rtl/word_serializer_if.sv | 20 ++
 rtl/word_serializer.sv | 125 ++++++++++++
 tb/tb_word_serializer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ser_pkg
// Description : Shared types and defaults for the word_serializer block:
//               FSM state encoding, default word width and idle line level.
// Revision    : 1.0 - initial release
// ============================================================================
package ser_pkg;

  // Shifter FSM: IDLE = shifter empty, SHIFT = shifter emitting bits
  typedef enum logic [0:0] {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  localparam int   SER_WIDTH    = 8;
  localparam logic SER_IDLE_BIT = 1'b0;

endpackage : ser_pkg
`default_nettype wire

// File: rtl/word_serializer_if.sv
`default_nettype none
// ============================================================================
// Interface   : word_serializer_if
// Description : Parallel word valid/ready handshake feeding the serializer.
//               master = word producer, slave = serializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface word_serializer_if
  import ser_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (output din, output din_valid, input  din_ready);
  modport slave  (input  din, input  din_valid, output din_ready);
endinterface : word_serializer_if
`default_nettype wire

// File: rtl/word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : word_serializer
// Description : Parallel-to-serial front end. Accepts WIDTH-bit words over a
//               valid/ready handshake (one-word holding register for gapless
//               streaming) and emits one registered bit per clock on x.
//               Build option: WORD_SERIALIZER_LSB_FIRST_EN selects LSB-first
//               emission; default build emits MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module word_serializer
  import ser_pkg::*;
#(
  parameter int   WIDTH    = SER_WIDTH,
  parameter logic IDLE_BIT = SER_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst,
  word_serializer_if.slave in_if,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_t       state, state_nxt;
  logic [WIDTH-1:0] sh, sh_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic             hold_v, hold_v_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             xfer;

  // Bit that goes onto the line first from a freshly loaded/advanced shifter
  function automatic logic head(input logic [WIDTH-1:0] w);
`ifdef WORD_SERIALIZER_LSB_FIRST_EN
    return w[0];
`else
    return w[WIDTH-1];
`endif
  endfunction

  // Shifter contents after the current head bit has been emitted
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
`ifdef WORD_SERIALIZER_LSB_FIRST_EN
    return w >> 1;
`else
    return w << 1;
`endif
  endfunction

  assign in_if.din_ready = !hold_v;
  assign xfer            = in_if.din_valid && !hold_v;
  assign busy            = (state == SER_SHIFT) || hold_v;

  // Next-state, shifter, counter and holding-register decisions
  always_comb begin
    state_nxt  = state;
    sh_nxt     = sh;
    cnt_nxt    = cnt;
    hold_nxt   = hold;
    hold_v_nxt = hold_v;
    case (state)
      SER_IDLE: begin
        if (xfer) begin
          sh_nxt    = in_if.din;
          cnt_nxt   = '0;
          state_nxt = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        if (cnt != CNT_LAST) begin
          sh_nxt  = advance(sh);
          cnt_nxt = cnt + 1'b1;
          if (xfer) begin
            hold_nxt   = in_if.din;
            hold_v_nxt = 1'b1;
          end
        end else if (hold_v) begin
          // Held word drains into the shifter; din_ready is low here, so
          // no new word can arrive in the same cycle.
          sh_nxt     = hold;
          hold_v_nxt = 1'b0;
          cnt_nxt    = '0;
        end else if (xfer) begin
          sh_nxt  = in_if.din;
          cnt_nxt = '0;
        end else begin
          cnt_nxt   = '0;
          state_nxt = SER_IDLE;
        end
      end
      default: begin
        state_nxt = SER_IDLE;
      end
    endcase
  end

  // State/data registers and registered serial outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SER_IDLE;
      sh        <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_v    <= 1'b0;
      x         <= IDLE_BIT;
      x_valid   <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      sh        <= sh_nxt;
      cnt       <= cnt_nxt;
      hold      <= hold_nxt;
      hold_v    <= hold_v_nxt;
      x         <= (state_nxt == SER_SHIFT) ? head(sh_nxt) : IDLE_BIT;
      x_valid   <= (state_nxt == SER_SHIFT);
      word_done <= (state_nxt == SER_SHIFT) && (cnt_nxt == CNT_LAST);
    end
  end

endmodule : word_serializer
`default_nettype wire

// File: tb/tb_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_word_serializer
// Description : Self-checking bench for word_serializer with a scoreboard of
//               expected serial bits and a behavioural 11000 detector.
//               Honours WORD_SERIALIZER_LSB_FIRST_EN for bit order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_word_serializer;
  import ser_pkg::*;

  localparam int   W    = 8;
  localparam logic IDLE = 1'b0;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic clk;
  logic rst;
  logic x, x_valid, word_done, busy;

  word_serializer_if #(.WIDTH(W)) bus ();

  word_serializer #(.WIDTH(W), .IDLE_BIT(IDLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_if     (bus),
    .x         (x),
    .x_valid   (x_valid),
    .word_done (word_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         cyc;
  int         det_cycle;
  logic       det_xv;
  logic [4:0] det_hist;
  exp_t       q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Emission order of bit i of a word
  function automatic logic emit(input logic [W-1:0] w, input int i);
`ifdef WORD_SERIALIZER_LSB_FIRST_EN
    return w[i];
`else
    return w[W-1-i];
`endif
  endfunction

  task automatic det_clear();
    det_hist  = '0;
    det_cycle = -1;
    det_xv    = 1'b1;
    cyc       = 0;
  endtask

  // One clock: record any transfer, advance, then check outputs at negedge
  task automatic cycle();
    exp_t e;
    logic have;
    logic hold_full;
    if (bus.din_valid && bus.din_ready) begin
      for (int i = 0; i < W; i++) q.push_back('{b: emit(bus.din, i), last: (i == W-1)});
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    // Non-overlapping 11000 detector on the raw line
    det_hist = {det_hist[3:0], x};
    if (det_hist == 5'b11000) begin
      if (det_cycle < 0) begin
        det_cycle = cyc;
        det_xv    = x_valid;
      end
      det_hist = '0;
    end
    have = (q.size() > 0);
    if (have) begin
      e = q.pop_front();
      chk("x_valid", {31'd0, x_valid}, 32'd1);
      chk("x_bit", {31'd0, x}, {31'd0, e.b});
      chk("word_done", {31'd0, word_done}, {31'd0, e.last});
    end else begin
      chk("x_valid_idle", {31'd0, x_valid}, 32'd0);
      chk("x_idle", {31'd0, x}, {31'd0, IDLE});
      chk("word_done_idle", {31'd0, word_done}, 32'd0);
    end
    hold_full = (q.size() >= W);
    chk("din_ready", {31'd0, bus.din_ready}, {31'd0, !hold_full});
    chk("busy", {31'd0, busy}, {31'd0, have || hold_full});
  endtask

  initial begin
    int         guard;
    logic [W-1:0] w;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    rst           = 1'b1;
    det_clear();
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_x", {31'd0, x}, {31'd0, IDLE});
    chk("rst_x_valid", {31'd0, x_valid}, 32'd0);
    chk("rst_word_done", {31'd0, word_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_din_ready", {31'd0, bus.din_ready}, 32'd1);
    rst = 1'b1;
    cycle();

    // Single word 11000000 in emit order; detector fires on 5th bit
    det_clear();
`ifdef WORD_SERIALIZER_LSB_FIRST_EN
    w = 8'h03;
`else
    w = 8'hC0;
`endif
    bus.din = w;
    bus.din_valid = 1'b1;
    cycle();
    bus.din_valid = 1'b0;
    bus.din = 8'hFF;          // ignored while valid is low
    repeat (9) cycle();
    chk("det_first_word", det_cycle, 32'd5);

    // Back-to-back words with valid held high
    bus.din = 8'hA5;
    bus.din_valid = 1'b1;
    cycle();
    bus.din = 8'h3C;
    cycle();
    bus.din_valid = 1'b0;
    repeat (17) cycle();
    chk("b2b_drained", q.size(), 32'd0);

    // Three words offered continuously; third waits for hold to drain
    bus.din = 8'h81;
    bus.din_valid = 1'b1;
    cycle();
    bus.din = 8'h5A;
    cycle();
    bus.din = 8'hE7;
    guard = 0;
    while (!bus.din_ready && guard < 20) begin
      cycle();
      guard++;
    end
    chk("third_wait", guard, 32'd7);
    cycle();
    bus.din_valid = 1'b0;
    repeat (25) cycle();
    chk("three_drained", q.size(), 32'd0);

    // Asynchronous reset during bit 4 of 8'hFF
    bus.din = 8'hFF;
    bus.din_valid = 1'b1;
    cycle();
    bus.din_valid = 1'b0;
    repeat (3) cycle();
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_x", {31'd0, x}, {31'd0, IDLE});
    chk("mid_rst_x_valid", {31'd0, x_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_word_done", {31'd0, word_done}, 32'd0);
    chk("mid_rst_din_ready", {31'd0, bus.din_ready}, 32'd1);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (10) cycle();

    // Idle fill after a word ending ...110 completes a match off-payload
    det_clear();
`ifdef WORD_SERIALIZER_LSB_FIRST_EN
    w = 8'h60;
`else
    w = 8'h06;
`endif
    bus.din = w;
    bus.din_valid = 1'b1;
    cycle();
    bus.din_valid = 1'b0;
    repeat (11) cycle();
    chk("det_idle_fill", det_cycle, 32'd10);
    chk("det_idle_xv", {31'd0, det_xv}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_word_serializer
`default_nettype wire
